// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame parameters.
// Intended for reuse by both the transmitter and the receiver.
package uart_pkg;

    // Frame sequencing states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

    // Default frame format: 8 data bits, 16x oversampling, one stop bit
    localparam int unsigned DBIT_DEF    = 8;
    localparam int unsigned OVS_DEF     = 16;
    localparam int unsigned SB_TICK_DEF = 16;

    // Larger of two values, used to size tick counters
    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, stop period.
// Bit timing comes from an external oversample strobe s_tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DBIT    = DBIT_DEF,
    parameter int unsigned OVS     = OVS_DEF,
    parameter int unsigned SB_TICK = SB_TICK_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int unsigned CW = $clog2(max2(OVS, SB_TICK));
    localparam int unsigned NW = $clog2(DBIT);

    uart_state_e     state_q, state_d;
    logic [CW-1:0]   s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;
    logic [DBIT-1:0] b_shifted;

    // State and datapath registers; reset leaves the line idle high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            s_cnt_q <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic; tx_d is the line level for the following cycle
    always_comb begin
        state_d      = state_q;
        s_cnt_d      = s_cnt_q;
        n_d          = n_q;
        b_d          = b_q;
        tx_d         = tx_q;
        tx_done_tick = 1'b0;
        b_shifted    = b_q >> 1;

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    state_d = StStart;
                    s_cnt_d = '0;
                    b_d     = din;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                tx_d = 1'b0;
                if (s_tick) begin
                    if (s_cnt_q == CW'(OVS - 1)) begin
                        state_d = StData;
                        s_cnt_d = '0;
                        n_d     = '0;
                        tx_d    = b_q[0];
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                tx_d = b_q[0];
                if (s_tick) begin
                    if (s_cnt_q == CW'(OVS - 1)) begin
                        s_cnt_d = '0;
                        b_d     = b_shifted;
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end else begin
                            n_d  = n_q + 1'b1;
                            tx_d = b_shifted[0];
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            StStop: begin
                tx_d = 1'b1;
                if (s_tick) begin
                    if (s_cnt_q == CW'(SB_TICK - 1)) begin
                        state_d      = StIdle;
                        s_cnt_d      = '0;
                        tx_done_tick = 1'b1;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != StIdle);

endmodule
